// File: rtl/sti_rx_if.sv
`timescale 1ns/1ps
// sti_rx_if: serial input and parallel output handshake bundle for sti_rx.
// The slave modport is the receiver side; the master modport drives serial data and consumes words.
interface sti_rx_if;
    logic        si_data;
    logic        si_valid;
    logic [15:0] po_data;
    logic        po_valid;
    logic        po_ready;

    modport master (
        output si_data,
        output si_valid,
        output po_ready,
        input  po_data,
        input  po_valid
    );

    modport slave (
        input  si_data,
        input  si_valid,
        input  po_ready,
        output po_data,
        output po_valid
    );
endinterface

// File: rtl/sti_rx.sv
`timescale 1ns/1ps
// sti_rx: serial-to-parallel receiver, 8/16/24/32-bit frames reduced to a 16-bit word.
// Define STI_RX_ERRCNT_EN to add the saturating err_cnt[7:0] output.
module sti_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cfg_length,
    input  logic       cfg_fill,
    input  logic       cfg_msb,
    input  logic       cfg_low,
    sti_rx_if.slave    bus,
    output logic       err_short,
    output logic       err_ovf
`ifdef STI_RX_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    // Reduce the assembled frame to the 16-bit output word.
    function automatic logic [15:0] extract_word(input logic [31:0] w, input logic [1:0] len,
                                                 input logic fill, input logic low);
        logic [15:0] r;
        case (len)
            2'd0:    r = low ? {w[7:0], 8'h00} : {8'h00, w[7:0]};
            2'd1:    r = w[15:0];
            2'd2:    r = fill ? w[23:8] : w[15:0];
            2'd3:    r = fill ? w[31:16] : w[15:0];
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  count_r, count_s;
    logic [31:0] sr_r, sr_s;
    logic [1:0]  len_r, len_s;
    logic        fill_r, fill_s;
    logic        msb_r, msb_s;
    logic        low_r, low_s;
    logic [15:0] po_data_r, po_data_s;
    logic        po_valid_r, po_valid_s;
    logic        err_short_r, err_short_s;
    logic        err_ovf_r, err_ovf_s;
    logic        take_s;
    logic        first_s;
    logic [4:0]  last_s;
    logic [4:0]  pos_s;

    // Next-state, bit placement and output-register update.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        sr_s        = sr_r;
        po_data_s   = po_data_r;
        err_short_s = 1'b0;
        err_ovf_s   = 1'b0;
        take_s      = 1'b0;
        // A zero count means the next sampled bit opens a frame, so cfg is taken live.
        first_s     = (count_r == 5'd0);
        len_s       = first_s ? cfg_length : len_r;
        fill_s      = first_s ? cfg_fill   : fill_r;
        msb_s       = first_s ? cfg_msb    : msb_r;
        low_s       = first_s ? cfg_low    : low_r;
        last_s      = {len_s, 3'b111};
        pos_s       = msb_s ? (last_s - count_r) : count_r;

        if (po_valid_r && bus.po_ready) begin
            po_valid_s = 1'b0;
        end else begin
            po_valid_s = po_valid_r;
        end

        case (state_r)
            IDLE: begin
                if (bus.si_valid) begin
                    state_s = SHIFT;
                    take_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (bus.si_valid) begin
                    take_s = 1'b1;
                end else begin
                    state_s     = IDLE;
                    count_s     = 5'd0;
                    err_short_s = (count_r != 5'd0);
                end
            end
            default: begin
                state_s = IDLE;
                count_s = 5'd0;
            end
        endcase

        if (take_s) begin
            sr_s        = first_s ? 32'h0000_0000 : sr_r;
            sr_s[pos_s] = bus.si_data;
            if (count_r == last_s) begin
                count_s = 5'd0;
                if (!po_valid_r || bus.po_ready) begin
                    po_data_s  = extract_word(sr_s, len_s, fill_s, low_s);
                    po_valid_s = 1'b1;
                end else begin
                    err_ovf_s = 1'b1;
                end
            end else begin
                count_s = count_r + 5'd1;
            end
        end else begin
            sr_s = sr_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            count_r     <= 5'd0;
            sr_r        <= 32'h0000_0000;
            len_r       <= 2'd0;
            fill_r      <= 1'b0;
            msb_r       <= 1'b0;
            low_r       <= 1'b0;
            po_data_r   <= 16'h0000;
            po_valid_r  <= 1'b0;
            err_short_r <= 1'b0;
            err_ovf_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            sr_r        <= sr_s;
            len_r       <= len_s;
            fill_r      <= fill_s;
            msb_r       <= msb_s;
            low_r       <= low_s;
            po_data_r   <= po_data_s;
            po_valid_r  <= po_valid_s;
            err_short_r <= err_short_s;
            err_ovf_r   <= err_ovf_s;
        end
    end

    assign bus.po_data  = po_data_r;
    assign bus.po_valid = po_valid_r;
    assign err_short    = err_short_r;
    assign err_ovf      = err_ovf_r;

`ifdef STI_RX_ERRCNT_EN
    logic [7:0] err_cnt_r;

    // Saturating error counter, stepping on the same edge that raises a pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_r <= 8'h00;
        end else if ((err_short_s || err_ovf_s) && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_sti_rx.sv
`timescale 1ns/1ps
// tb_sti_rx: directed, table-driven and randomized checks of sti_rx against a queue-based model.
module tb_sti_rx;

    logic       clk;
    logic       reset;
    logic [1:0] cfg_length;
    logic       cfg_fill;
    logic       cfg_msb;
    logic       cfg_low;
    logic       err_short;
    logic       err_ovf;
`ifdef STI_RX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    sti_rx_if bus_i ();

    sti_rx dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_length (cfg_length),
        .cfg_fill   (cfg_fill),
        .cfg_msb    (cfg_msb),
        .cfg_low    (cfg_low),
        .bus        (bus_i),
        .err_short  (err_short),
        .err_ovf    (err_ovf)
`ifdef STI_RX_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: frame bits collected in a queue, word rebuilt by weighting.
    bit          m_bits[$];
    int          m_len, m_fill, m_msb, m_low;
    logic [15:0] m_data;
    bit          m_valid, m_short, m_ovf;
    int          m_errcnt;

    typedef struct {
        logic [1:0]  len;
        logic        fill;
        logic        msb;
        logic        low;
        logic [31:0] w;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic mdl_reset();
        m_bits.delete();
        m_data = 16'h0000; m_valid = 0; m_short = 0; m_ovf = 0; m_errcnt = 0;
    endtask

    task automatic mdl_step(input bit d, input bit v, input bit rdy);
        int          n;
        logic [31:0] w;
        logic [15:0] r;
        bit          free;
        m_short = 0; m_ovf = 0;
        free = !m_valid || rdy;
        if (m_valid && rdy) m_valid = 0;
        if (v) begin
            if (m_bits.size() == 0) begin
                m_len = int'(cfg_length); m_fill = int'(cfg_fill);
                m_msb = int'(cfg_msb);    m_low  = int'(cfg_low);
            end
            m_bits.push_back(d);
            n = 8 * (m_len + 1);
            if (m_bits.size() == n) begin
                w = 0;
                for (int i = 0; i < n; i++)
                    if (m_bits[i]) w = w + (32'd1 << (m_msb != 0 ? n - 1 - i : i));
                if (n == 8)       r = 16'((m_low != 0) ? (w & 32'hFF) * 256 : (w & 32'hFF));
                else if (n == 16) r = w[15:0];
                else              r = 16'((m_fill != 0) ? (w >> (n - 16)) : w);
                if (free) begin m_data = r; m_valid = 1; end
                else m_ovf = 1;
                m_bits.delete();
            end
        end else begin
            if (m_bits.size() != 0) m_short = 1;
            m_bits.delete();
        end
        if ((m_short || m_ovf) && m_errcnt < 255) m_errcnt++;
    endtask

    // One clock: apply inputs, advance model, check every output after the edge.
    task automatic drive_cycle(input bit d, input bit v, input bit rdy);
        bus_i.si_data  = d;
        bus_i.si_valid = v;
        bus_i.po_ready = rdy;
        mdl_step(d, v, rdy);
        @(posedge clk);
        #1;
        cyc++;
        chk("po_data",   32'(bus_i.po_data),  32'(m_data));
        chk("po_valid",  32'(bus_i.po_valid), 32'(m_valid));
        chk("err_short", 32'(err_short),      32'(m_short));
        chk("err_ovf",   32'(err_ovf),        32'(m_ovf));
`ifdef STI_RX_ERRCNT_EN
        chk("err_cnt",   32'(err_cnt),        32'(m_errcnt));
`endif
    endtask

    task automatic send_frame(input logic [1:0] len, input logic fill, input logic msb,
                              input logic low, input logic [31:0] w, input bit rdy);
        int n;
        n = 8 * (int'(len) + 1);
        cfg_length = len; cfg_fill = fill; cfg_msb = msb; cfg_low = low;
        for (int i = 0; i < n; i++)
            drive_cycle(msb ? w[n - 1 - i] : w[i], 1'b1, rdy);
    endtask

    task automatic do_reset();
        bus_i.si_valid = 1'b0; bus_i.si_data = 1'b0; bus_i.po_ready = 1'b0;
        reset = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] bits8;
        vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_005A, 16'h005A};
        vecs[1] = '{2'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0081, 16'h8100};
        vecs[2] = '{2'd1, 1'b0, 1'b1, 1'b0, 32'h0000_8001, 16'h8001};
        vecs[3] = '{2'd2, 1'b1, 1'b0, 1'b0, 32'h00AB_CDEF, 16'hABCD};
        vecs[4] = '{2'd2, 1'b0, 1'b1, 1'b0, 32'h00AB_CDEF, 16'hCDEF};
        vecs[5] = '{2'd3, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 16'h5678};
        vecs[6] = '{2'd3, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 16'h1234};

        cfg_length = 2'd0; cfg_fill = 1'b0; cfg_msb = 1'b0; cfg_low = 1'b0;
        do_reset();
        chk("rst_data",  32'(bus_i.po_data),  32'h0);
        chk("rst_valid", 32'(bus_i.po_valid), 32'h0);
        chk("rst_short", 32'(err_short),      32'h0);
        chk("rst_ovf",   32'(err_ovf),        32'h0);

        // 8-bit MSB-first, byte in the low then the high half.
        bits8 = 8'hA5;
        send_frame(2'd0, 1'b0, 1'b1, 1'b0, 32'(bits8), 1'b1);
        chk("t8_low_data", 32'(bus_i.po_data), 32'h00A5);
        chk("t8_low_vld",  32'(bus_i.po_valid), 32'h1);
        drive_cycle(1'b0, 1'b0, 1'b1);
        send_frame(2'd0, 1'b0, 1'b1, 1'b1, 32'(bits8), 1'b1);
        chk("t8_high_data", 32'(bus_i.po_data), 32'hA500);
        drive_cycle(1'b0, 1'b0, 1'b1);

        // 16-bit LSB-first, valid for exactly one cycle with ready held.
        send_frame(2'd1, 1'b0, 1'b0, 1'b0, 32'h1234, 1'b1);
        chk("t16_data", 32'(bus_i.po_data), 32'h1234);
        chk("t16_vld1", 32'(bus_i.po_valid), 32'h1);
        drive_cycle(1'b0, 1'b0, 1'b1);
        chk("t16_vld0", 32'(bus_i.po_valid), 32'h0);

        // 32-bit fill=1 back-to-back with 24-bit fill=0.
        send_frame(2'd3, 1'b1, 1'b1, 1'b0, 32'hBEEF_0000, 1'b1);
        chk("tb2b_w1", 32'(bus_i.po_data), 32'hBEEF);
        send_frame(2'd2, 1'b0, 1'b1, 1'b0, 32'h0000_0F0F, 1'b1);
        chk("tb2b_w2", 32'(bus_i.po_data), 32'h0F0F);
        chk("tb2b_ovf", 32'(err_ovf), 32'h0);
        drive_cycle(1'b0, 1'b0, 1'b1);

        // Short frame: five bits then si_valid drops.
        cfg_length = 2'd0; cfg_msb = 1'b1; cfg_low = 1'b0;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1);
        chk("tshort_pulse", 32'(err_short), 32'h1);
        chk("tshort_vld",   32'(bus_i.po_valid), 32'h0);
        drive_cycle(1'b0, 1'b0, 1'b1);
        chk("tshort_clear", 32'(err_short), 32'h0);
        send_frame(2'd0, 1'b0, 1'b1, 1'b0, 32'h3C, 1'b1);
        chk("tshort_next", 32'(bus_i.po_data), 32'h003C);
        drive_cycle(1'b0, 1'b0, 1'b1);

        // Overflow with the consumer stalled.
        do_reset();
        send_frame(2'd1, 1'b0, 1'b1, 1'b0, 32'h1111, 1'b0);
        chk("tovf_w1", 32'(bus_i.po_data), 32'h1111);
        send_frame(2'd1, 1'b0, 1'b1, 1'b0, 32'h2222, 1'b0);
        chk("tovf_keep",  32'(bus_i.po_data), 32'h1111);
        chk("tovf_pulse", 32'(err_ovf), 32'h1);
`ifdef STI_RX_ERRCNT_EN
        chk("tovf_cnt", 32'(err_cnt), 32'h1);
`endif
        drive_cycle(1'b0, 1'b0, 1'b0);
        chk("tovf_clear", 32'(err_ovf), 32'h0);
        drive_cycle(1'b0, 1'b0, 1'b1);

        // Reset in the middle of a 32-bit frame.
        cfg_length = 2'd3; cfg_fill = 1'b0; cfg_msb = 1'b1;
        for (int i = 0; i < 10; i++) drive_cycle(i[0], 1'b1, 1'b0);
        reset = 1'b0;
        mdl_reset();
        #1;
        chk("trst_data",  32'(bus_i.po_data),  32'h0);
        chk("trst_vld",   32'(bus_i.po_valid), 32'h0);
        chk("trst_short", 32'(err_short),      32'h0);
        chk("trst_ovf",   32'(err_ovf),        32'h0);
        bus_i.si_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b1);
        chk("trst_noerr", 32'(err_short), 32'h0);
        send_frame(2'd1, 1'b0, 1'b1, 1'b0, 32'hCAFE, 1'b1);
        chk("trst_cafe", 32'(bus_i.po_data), 32'hCAFE);
        drive_cycle(1'b0, 1'b0, 1'b1);

        // Table of frame formats, sent back-to-back.
        for (int k = 0; k < 7; k++) begin
            send_frame(vecs[k].len, vecs[k].fill, vecs[k].msb, vecs[k].low, vecs[k].w, 1'b1);
            chk($sformatf("vec%0d", k), 32'(bus_i.po_data), 32'(vecs[k].exp));
        end
        drive_cycle(1'b0, 1'b0, 1'b1);

        // Randomized traffic, including mid-frame cfg changes and stalls.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                cfg_length = 2'($urandom_range(0, 3));
                cfg_fill   = 1'($urandom_range(0, 1));
                cfg_msb    = 1'($urandom_range(0, 1));
                cfg_low    = 1'($urandom_range(0, 1));
            end
            drive_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 15) != 0,
                        $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
